// File: rtl/mat_link_pkg.sv
// ----------------------------------------------------------------------------
// mat_link_pkg
// Constants shared by both ends of the matrix-multiply UART link: the frame
// header and tags, the frame length and byte positions, and the state encoding
// used by the result transmitter.
// Used by result_frame_tx and by the receive-side frame parser in top.
// ----------------------------------------------------------------------------
package mat_link_pkg;

   localparam logic [7:0] HEADER     = 8'hFF;
   localparam logic [7:0] TAG_A      = 8'h00;
   localparam logic [7:0] TAG_B      = 8'h01;
   localparam logic [7:0] RESULT_TAG = 8'h02;

   localparam int FRAME_LEN = 8;
   localparam int IDX_W     = $clog2(FRAME_LEN);

   // Position of each byte inside a result frame
   localparam logic [IDX_W-1:0] IDX_HDR = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_TAG = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_JOB = IDX_W'(2);
   localparam logic [IDX_W-1:0] IDX_C11 = IDX_W'(3);
   localparam logic [IDX_W-1:0] IDX_C12 = IDX_W'(4);
   localparam logic [IDX_W-1:0] IDX_C21 = IDX_W'(5);
   localparam logic [IDX_W-1:0] IDX_C22 = IDX_W'(6);
   localparam logic [IDX_W-1:0] IDX_CHK = IDX_W'(7);

   // Transmitter state encoding
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_SEND      = 3'd1;
   localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
   localparam logic [2:0] ST_WAIT_DONE = 3'd3;
   localparam logic [2:0] ST_DONE      = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE      = ST_IDLE,
      S_SEND      = ST_SEND,
      S_WAIT_ACK  = ST_WAIT_ACK,
      S_WAIT_DONE = ST_WAIT_DONE,
      S_DONE      = ST_DONE
   } tx_state_e;

endpackage

// File: rtl/result_frame_tx.sv
// ----------------------------------------------------------------------------
// result_frame_tx
// Packs a 2x2 result matrix and its job id into one 8-byte frame
//   FF, 02, job_id, c11, c12, c21, c22, CHK   (CHK = job+c11+c12+c21+c22 mod 256)
// and hands it byte by byte to the UART transmitter through the
// tx_byte/tx_enable/tx_busy handshake.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      send one frame (accepted only while idle)
//   job_id     job number echoed in the frame
//   c11..c22   result matrix elements
//   tx_busy    UART is shifting a byte out
//   tx_byte    byte for the UART, valid with tx_enable
//   tx_enable  one-cycle load strobe to the UART
//   busy       frame in progress
//   done       one-cycle pulse, frame fully transmitted
//   err        one-cycle pulse, UART did not acknowledge a byte, frame aborted
// ----------------------------------------------------------------------------
import mat_link_pkg::*;

module result_frame_tx #(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] job_id,
   input  logic [7:0] c11,
   input  logic [7:0] c12,
   input  logic [7:0] c21,
   input  logic [7:0] c22,
   input  logic       tx_busy,
   output logic [7:0] tx_byte,
   output logic       tx_enable,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int               CNT_W   = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT);

   tx_state_e        state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [7:0]       chk_q, chk_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       tx_byte_q, tx_byte_d;
   logic             tx_en_q, tx_en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   // Frame contents captured at start; not reset, only read after a load
   logic [7:0] job_q, c11_q, c12_q, c21_q, c22_q;
   logic       load;
   logic [7:0] cur_byte;

   function automatic logic [7:0] frame_byte(
      input logic [IDX_W-1:0] idx,
      input logic [7:0]       job,
      input logic [7:0]       e11,
      input logic [7:0]       e12,
      input logic [7:0]       e21,
      input logic [7:0]       e22,
      input logic [7:0]       chk
   );
      logic [7:0] b;
      case (idx)
         IDX_HDR: b = HEADER;
         IDX_TAG: b = RESULT_TAG;
         IDX_JOB: b = job;
         IDX_C11: b = e11;
         IDX_C12: b = e12;
         IDX_C21: b = e21;
         IDX_C22: b = e22;
         default: b = chk;
      endcase
      return b;
   endfunction

   assign cur_byte = frame_byte(idx_q, job_q, c11_q, c12_q, c21_q, c22_q, chk_q);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      chk_d     = chk_q;
      cnt_d     = cnt_q;
      tx_byte_d = tx_byte_q;
      tx_en_d   = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      load      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               load    = 1'b1;
               busy_d  = 1'b1;
               idx_d   = IDX_HDR;
               chk_d   = 8'h00;
               state_d = S_SEND;
            end
         end

         S_SEND: begin
            if (!tx_busy) begin
               tx_byte_d = cur_byte;
               tx_en_d   = 1'b1;
               cnt_d     = '0;
               // Checksum accumulates payload bytes as they leave, so it is
               // complete by the time the CHK slot is reached.
               if (idx_q >= IDX_JOB && idx_q <= IDX_C22) begin
                  chk_d = chk_q + cur_byte;
               end
               state_d = S_WAIT_ACK;
            end
         end

         S_WAIT_ACK: begin
            if (tx_busy) begin
               state_d = S_WAIT_DONE;
            end else begin
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
               // This wait cycle brings the count to ACK_TIMEOUT: give up
               if (cnt_q >= CNT_MAX - 1'b1) begin
                  err_d   = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end
            end
         end

         S_WAIT_DONE: begin
            if (!tx_busy) begin
               idx_d = idx_q + 1'b1;
               if (idx_q == IDX_CHK) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_DONE;
               end else begin
                  state_d = S_SEND;
               end
            end
         end

         S_DONE: begin
            // done is visible during this cycle; start is accepted from IDLE next
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         chk_q     <= 8'h00;
         cnt_q     <= '0;
         tx_byte_q <= 8'h00;
         tx_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         chk_q     <= chk_d;
         cnt_q     <= cnt_d;
         tx_byte_q <= tx_byte_d;
         tx_en_q   <= tx_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         job_q <= job_id;
         c11_q <= c11;
         c12_q <= c12;
         c21_q <= c21;
         c22_q <= c22;
      end
   end

   assign tx_byte   = tx_byte_q;
   assign tx_enable = tx_en_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_result_frame_tx.sv
// ----------------------------------------------------------------------------
// tb_result_frame_tx
// Scoreboard bench for result_frame_tx: stimulus pushes the expected frame
// bytes (built from the frame rules with plain arithmetic) into a queue, a
// negedge monitor pops and compares every byte the DUT strobes out, and a
// small UART model answers tx_enable with a tx_busy burst.
// ----------------------------------------------------------------------------
module tb_result_frame_tx;

   localparam int ACK_TO = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] job_id, c11, c12, c21, c22;
   logic       tx_busy;
   logic [7:0] tx_byte;
   logic       tx_enable, busy, done, err;

   result_frame_tx #(.ACK_TIMEOUT(ACK_TO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .job_id(job_id),
      .c11(c11), .c12(c12), .c21(c21), .c22(c22), .tx_busy(tx_busy),
      .tx_byte(tx_byte), .tx_enable(tx_enable), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int         n_total = 0;
   int         n_pass  = 0;
   logic [7:0] exp_q[$];
   int         bytes_seen = 0, done_cnt = 0, err_cnt = 0;
   int         cyc = 0, last_en_cyc = 0, err_cyc = 0;
   bit         ack_mode   = 1'b1;
   bit         force_busy = 1'b0;
   int         busy_len   = 10;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
   endtask

   // Reference frame: header, tag, job, elements, 8-bit wrapped sum of job+elements
   task automatic push_frame(input logic [7:0] j, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d, input int npush);
      logic [7:0] f[8];
      int sum;
      sum = int'(j) + int'(a) + int'(b) + int'(c) + int'(d);
      f[0] = 8'hFF; f[1] = 8'h02; f[2] = j; f[3] = a; f[4] = b; f[5] = c; f[6] = d;
      f[7] = 8'(sum % 256);
      for (int i = 0; i < npush; i++) exp_q.push_back(f[i]);
   endtask

   // UART model: tx_busy rises one cycle after tx_enable and stays up busy_len cycles
   initial begin
      bit pending;
      int busy_left;
      pending   = 1'b0;
      busy_left = 0;
      tx_busy   = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            pending   = 1'b0;
            busy_left = 0;
         end else begin
            if (pending) begin
               pending   = 1'b0;
               busy_left = busy_len;
            end
            if (tx_enable && ack_mode) pending = 1'b1;
         end
         tx_busy = force_busy || (busy_left > 0);
         if (busy_left > 0) busy_left--;
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (tx_enable) begin
            check("en_while_uart_busy", {31'b0, tx_busy}, 32'd0);
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_byte: got 0x%0h, expected no byte (t=%0t)", tx_byte, $time);
            end else begin
               check("frame_byte", {24'b0, tx_byte}, {24'b0, exp_q.pop_front()});
            end
            bytes_seen++;
            last_en_cyc = cyc;
         end
         if (done) done_cnt++;
         if (err) begin
            err_cnt++;
            err_cyc = cyc;
         end
         if (done && err) check("done_and_err_together", 32'd1, 32'd0);
      end
   end

   task automatic send_frame(input logic [7:0] j, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d, input int npush);
      @(negedge clk);
      job_id = j; c11 = a; c12 = b; c21 = c; c22 = d;
      start  = 1'b1;
      push_frame(j, a, b, c, d, npush);
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic wait_end();
      int ev0;
      bit ok;
      ev0 = done_cnt + err_cnt;
      ok  = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         if (done_cnt + err_cnt != ev0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("frame_end_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_bytes(input int target);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         if (bytes_seen >= target) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("byte_wait_timeout", 32'd0, 32'd1);
   endtask

   task automatic frame_test(input logic [7:0] j, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
      int d0, e0, b0;
      d0 = done_cnt; e0 = err_cnt; b0 = bytes_seen;
      send_frame(j, a, b, c, d, 8);
      wait_end();
      @(posedge clk); #1;
      check("done_count",  done_cnt - d0, 1);
      check("err_count",   err_cnt - e0, 0);
      check("byte_count",  bytes_seen - b0, 8);
      check("queue_empty", exp_q.size(), 0);
      check("busy_after",  {31'b0, busy}, 32'd0);
      check("done_width",  {31'b0, done}, 32'd0);
   endtask

   initial begin
      int d0, e0, b0, b1;
      logic [7:0] r[5];

      rst_n = 1'b0; start = 1'b0;
      job_id = 8'h00; c11 = 8'h00; c12 = 8'h00; c21 = 8'h00; c22 = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_enable", {31'b0, tx_enable}, 32'd0);
      check("rst_tx_byte",   {24'b0, tx_byte}, 32'd0);
      check("rst_busy",      {31'b0, busy}, 32'd0);
      check("rst_done",      {31'b0, done}, 32'd0);
      check("rst_err",       {31'b0, err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Normal frame and checksum wrap
      frame_test(8'h07, 8'h05, 8'h06, 8'h07, 8'h08);
      frame_test(8'hFF, 8'h80, 8'h80, 8'h01, 8'h00);

      // Start while busy is ignored; inputs changed mid-frame do not leak in
      d0 = done_cnt; b0 = bytes_seen;
      send_frame(8'h07, 8'h05, 8'h06, 8'h07, 8'h08, 8);
      wait_bytes(b0 + 3);
      @(negedge clk);
      job_id = 8'h09; c11 = 8'hAA; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_end();
      repeat (30) @(posedge clk);
      #1;
      check("ignored_start_bytes", bytes_seen - b0, 8);
      check("ignored_start_done",  done_cnt - d0, 1);
      check("ignored_start_queue", exp_q.size(), 0);

      // Backpressure around start
      @(negedge clk);
      force_busy = 1'b1;
      repeat (20) @(posedge clk);
      b0 = bytes_seen;
      send_frame(8'h31, 8'h12, 8'h34, 8'h56, 8'h78, 8);
      repeat (20) @(posedge clk);
      #1;
      check("bp_no_enable", bytes_seen - b0, 0);
      check("bp_busy",      {31'b0, busy}, 32'd1);
      @(negedge clk);
      force_busy = 1'b0;
      wait_end();
      @(posedge clk); #1;
      check("bp_bytes", bytes_seen - b0, 8);
      check("bp_queue", exp_q.size(), 0);

      // Handshake timeout: UART never answers
      @(negedge clk);
      ack_mode = 1'b0;
      d0 = done_cnt; e0 = err_cnt; b0 = bytes_seen;
      send_frame(8'h44, 8'h01, 8'h02, 8'h03, 8'h04, 1);
      wait_end();
      @(posedge clk); #1;
      check("to_err_count",   err_cnt - e0, 1);
      check("to_done_count",  done_cnt - d0, 0);
      check("to_latency",     err_cyc - last_en_cyc, ACK_TO);
      check("to_bytes",       bytes_seen - b0, 1);
      check("to_busy",        {31'b0, busy}, 32'd0);
      check("to_err_width",   {31'b0, err}, 32'd0);
      @(negedge clk);
      ack_mode = 1'b1;
      frame_test(8'h45, 8'hDE, 8'hAD, 8'hBE, 8'hEF);

      // Reset in the middle of byte 5
      b0 = bytes_seen;
      send_frame(8'h5A, 8'h11, 8'h22, 8'h33, 8'h44, 8);
      wait_bytes(b0 + 5);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_tx_enable", {31'b0, tx_enable}, 32'd0);
      check("arst_busy",      {31'b0, busy}, 32'd0);
      check("arst_done",      {31'b0, done}, 32'd0);
      check("arst_err",       {31'b0, err}, 32'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      b1 = bytes_seen;
      repeat (40) @(posedge clk);
      #1;
      check("post_rst_silent", bytes_seen - b1, 0);
      check("post_rst_busy",   {31'b0, busy}, 32'd0);

      // Randomized frames with varying UART byte times
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         busy_len = int'($urandom_range(1, 12));
         for (int i = 0; i < 5; i++) r[i] = 8'($urandom);
         frame_test(r[0], r[1], r[2], r[3], r[4]);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
